signed_acc_with_overflow: RTL and testbench
===========================================

Name: signed_acc_with_overflow

Overview:
- Streaming signed accumulator; successor to the 4-bit combinational signed adder with overflow.
- Sums a frame of up to MAX_LEN signed W-bit operands arriving on a valid/ready stream.
- Emits the W-bit result, an exact overflow flag and the operand count on a valid/ready output.
- Sits between a sample source and downstream arithmetic stages in the arithmetic/pipelining exercises.

Parameters:
- W, 4, operand and result width (two's complement), W >= 2
- MAX_LEN, 8, maximum operands per frame; frame force-closes at this count, MAX_LEN >= 2
- CNT_W, $clog2(MAX_LEN+1), width of the count output (derived, not overridden)

Ports:
- clk  input  1  clock, all logic on rising edge
- rst  input  1  synchronous active-low reset
- in_valid  input  1  operand valid
- in_ready  output  1  block can accept an operand
- in_data  input  W  signed operand
- in_last  input  1  operand closes the frame
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts result
- out_sum  output  W  signed frame sum (wrapped, or saturated with SATURATE_EN)
- out_overflow  output  1  exact frame sum lies outside [-2^(W-1), 2^(W-1)-1]
- out_count  output  CNT_W  operands in the frame, 1..MAX_LEN

Behaviour:
- Reset (rst==0 at posedge): state=ACC, accumulator=0, count=0, out_valid=0, out_sum=0, out_overflow=0, out_count=0. Reset wins over every other event, including mid-frame and while out_valid=1; the partial frame and pending result are discarded.
- Accumulator width ACC_W = W + $clog2(MAX_LEN); sign-extend in_data before adding. The wide sum is exact and never wraps.
- States:
  - ACC: in_ready=1, out_valid=0. On in_valid&&in_ready: acc += sext(in_data), count += 1. If in_last, or count (pre-increment) == MAX_LEN-1, register the result and go to HOLD.
  - HOLD: in_ready=0, out_valid=1; out_* stable until handshake. On out_ready: acc=0, count=0, go to ACC. out_valid drops on the next cycle.
- Result registration (ACC->HOLD edge), using the final wide sum S including the current operand:
  - out_overflow = (S > 2^(W-1)-1) || (S < -2^(W-1)).
  - out_sum = S[W-1:0], or the saturated value (see Optional Feature).
  - out_count = final count.
- Latency: the result is visible (out_valid=1) the cycle after the closing operand handshake.
- A frame costs N input cycles plus at least 1 output cycle. There is no overlap between frames.
- Intermediate overflow that later cancels does not set out_overflow. Example: W=4, operands 7, 7, -8 gives S=6, out_overflow=0.
- A single-operand frame (in_last on the first beat) is legal: out_sum=in_data, out_overflow=0, out_count=1.
- in_data and in_last are ignored when in_valid=0. No input is consumed in HOLD.
- The module is fully synchronous. No combinational path from in_* to out_*. in_ready depends on state only.

Optional Feature:
- Macro: SIGNED_ACC_SATURATE_EN.
- Defined: when out_overflow=1, out_sum = 2^(W-1)-1 if S>0, or -2^(W-1) if S<0. out_overflow is still reported.
- Undefined: out_sum = S[W-1:0] (two's-complement wrap). All other behaviour is identical.

Test Plan:
- W=4: frame {3, 2, last} -> one cycle after the last handshake: out_sum=5, out_overflow=0, out_count=2.
- W=4: frame {7, 1, last} -> out_overflow=1, out_count=2; out_sum=-8 (4'b1000) without the macro, 7 with SIGNED_ACC_SATURATE_EN.
- W=4: frame {-8, -8, -8, last} -> S=-24, out_overflow=1; out_sum=-8 (4'b1000) wrapped, -8 saturated. Also frame {7, 7, -8, last} -> out_sum=6, out_overflow=0.
- MAX_LEN=8, W=4: eight operands of 1, in_last never asserted -> frame force-closes after beat 8: out_count=8, out_sum=-8 wrapped / 7 saturated, out_overflow=1. A ninth operand is held off by in_ready=0.
- Backpressure: hold out_ready=0 for 5 cycles with in_valid=1 -> out_valid, out_sum and out_count stable, in_ready=0, no operand consumed; assert out_ready -> in_ready=1 next cycle and the next frame starts from acc=0.
- Pull rst low mid-frame after 2 operands and again during HOLD -> next cycle out_valid=0, outputs 0, in_ready=1; a subsequent frame {1, last} yields out_sum=1, out_count=1.

Source files
------------

// File: rtl/signed_acc_with_overflow.sv
// Streaming signed frame accumulator with exact overflow flag and operand count.
// Optional saturation of the frame sum is enabled by defining SIGNED_ACC_SATURATE_EN.
module signed_acc_with_overflow #(
    parameter int W = 4,
    parameter int MAX_LEN = 8,
    localparam int CNT_W = $clog2(MAX_LEN + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_sum,
    output logic             out_overflow,
    output logic [CNT_W-1:0] out_count
);
    localparam int ACC_W = W + $clog2(MAX_LEN);

    typedef enum logic {
        ACC  = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t                  state_reg;
    logic signed [ACC_W-1:0] acc_reg;
    logic signed [ACC_W-1:0] acc_next;
    logic signed [ACC_W-1:0] operand_ext;
    logic [CNT_W-1:0]        count_reg;
    logic [CNT_W-1:0]        count_next;
    logic                    close_frame;
    logic                    sum_overflow;
    logic [W-1:0]            sum_result;

    assign operand_ext[W-1:0] = in_data;
    generate
        for (genvar gi = W; gi < ACC_W; gi++) begin : g_sext
            assign operand_ext[gi] = in_data[W-1];
        end
    endgenerate

    assign acc_next    = acc_reg + operand_ext;
    assign count_next  = count_reg + CNT_W'(1);
    assign close_frame = in_last || (count_reg == CNT_W'(MAX_LEN - 1));

    // The wide sum fits in W bits exactly when every bit from W-1 upward matches the sign.
    assign sum_overflow = !((&acc_next[ACC_W-1:W-1]) || !(|acc_next[ACC_W-1:W-1]));

`ifdef SIGNED_ACC_SATURATE_EN
    assign sum_result = !sum_overflow    ? acc_next[W-1:0] :
                        acc_next[ACC_W-1] ? {1'b1, {(W-1){1'b0}}} :
                                            {1'b0, {(W-1){1'b1}}};
`else
    assign sum_result = acc_next[W-1:0];
`endif

    assign in_ready  = (state_reg == ACC);
    assign out_valid = (state_reg == HOLD);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg    <= ACC;
            acc_reg      <= '0;
            count_reg    <= '0;
            out_sum      <= '0;
            out_overflow <= 1'b0;
            out_count    <= '0;
        end else begin
            case (state_reg)
                ACC: begin
                    if (in_valid) begin
                        acc_reg   <= acc_next;
                        count_reg <= count_next;
                        if (close_frame) begin
                            state_reg    <= HOLD;
                            out_sum      <= sum_result;
                            out_overflow <= sum_overflow;
                            out_count    <= count_next;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state_reg <= ACC;
                        acc_reg   <= '0;
                        count_reg <= '0;
                    end
                end
                default: state_reg <= ACC;
            endcase
        end
    end
endmodule

// File: tb/tb_signed_acc_with_overflow.sv
// Scoreboard bench for signed_acc_with_overflow; expected sum follows SIGNED_ACC_SATURATE_EN.
module tb_signed_acc_with_overflow;
    localparam int W = 4;
    localparam int MAX_LEN = 8;
    localparam int CNT_W = $clog2(MAX_LEN + 1);
    localparam int MAXP = (1 << (W - 1)) - 1;
    localparam int MINN = -(1 << (W - 1));

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [W-1:0]     in_data = '0;
    logic             in_last = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [W-1:0]     out_sum;
    logic             out_overflow;
    logic [CNT_W-1:0] out_count;

    signed_acc_with_overflow #(.W(W), .MAX_LEN(MAX_LEN)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
        .out_overflow(out_overflow), .out_count(out_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int sum;
        int ovf;
        int cnt;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   m_sum   = 0;
    int   m_cnt   = 0;
    bit   exp_hold = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: exact integer frame sum, classified against the W-bit signed range.
    task automatic push_result();
        exp_t e;
        int   tmp;
        e.ovf = ((m_sum > MAXP) || (m_sum < MINN)) ? 1 : 0;
        tmp = m_sum;
`ifdef SIGNED_ACC_SATURATE_EN
        if (e.ovf != 0) tmp = (m_sum > 0) ? MAXP : MINN;
`endif
        e.sum = int'(tmp[W-1:0]);
        e.cnt = m_cnt;
        exp_q.push_back(e);
        $display("[TB] frame closed: sum=%0d count=%0d overflow=%0d", m_sum, m_cnt, e.ovf);
    endtask

    task automatic cycle(input bit v, input int d, input bit l, input bit ordy);
        @(negedge clk);
        check("in_ready", int'(in_ready), exp_hold ? 0 : 1);
        check("out_valid", int'(out_valid), exp_hold ? 1 : 0);
        in_valid  = v;
        in_data   = d[W-1:0];
        in_last   = l;
        out_ready = ordy;
        if (!exp_hold) begin
            if (v) begin
                m_sum += int'($signed(in_data));
                m_cnt++;
                if (l || m_cnt == MAX_LEN) begin
                    push_result();
                    exp_hold = 1'b1;
                    m_sum = 0;
                    m_cnt = 0;
                end
            end
        end else if (ordy) begin
            exp_hold = 1'b0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst       = 1'b0;
        in_valid  = 1'b1;
        in_data   = W'($urandom);
        in_last   = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        exp_q.delete();
        exp_hold = 1'b0;
        m_sum = 0;
        m_cnt = 0;
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_out_sum", int'(out_sum), 0);
        check("rst_out_overflow", int'(out_overflow), 0);
        check("rst_out_count", int'(out_count), 0);
        $display("[TB] reset applied");
        rst      = 1'b1;
        in_valid = 1'b0;
    endtask

    // Monitor: compares every cycle the result is presented, pops on handshake.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (out_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_result: got sum=%0d count=%0d, expected no result",
                             out_sum, out_count);
                end else begin
                    check("out_sum", int'(out_sum), exp_q[0].sum);
                    check("out_overflow", int'(out_overflow), exp_q[0].ovf);
                    check("out_count", int'(out_count), exp_q[0].cnt);
                    if (out_ready) begin
                        $display("[TB] result accepted: sum=%0d overflow=%0d count=%0d",
                                 out_sum, out_overflow, out_count);
                        void'(exp_q.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        do_reset();

        // Plain frame {3, 2}
        cycle(1, 3, 0, 0);
        cycle(1, 2, 1, 0);
        cycle(0, 0, 0, 1);
        // Positive overflow {7, 1}
        cycle(1, 7, 0, 0);
        cycle(1, 1, 1, 1);
        cycle(0, 0, 0, 1);
        // Negative overflow {-8, -8, -8}
        cycle(1, -8, 0, 0);
        cycle(1, -8, 0, 0);
        cycle(1, -8, 1, 0);
        cycle(0, 0, 0, 1);
        // Intermediate overflow cancels {7, 7, -8}
        cycle(1, 7, 0, 0);
        cycle(1, 7, 0, 0);
        cycle(1, -8, 1, 0);
        cycle(0, 0, 0, 1);
        // Single-operand frame
        cycle(1, -3, 1, 0);
        cycle(0, 0, 0, 1);
        // Force-close after MAX_LEN beats, then backpressure with in_valid held high
        for (int i = 0; i < MAX_LEN + 1; i++) cycle(1, 1, 0, 0);
        for (int i = 0; i < 5; i++) cycle(1, 5, 0, 0);
        cycle(1, 5, 1, 1);
        cycle(1, 2, 1, 0);
        cycle(0, 0, 0, 1);
        // Reset mid-frame, then reset during HOLD
        cycle(1, 3, 0, 0);
        cycle(1, 3, 0, 0);
        do_reset();
        cycle(1, 5, 0, 0);
        cycle(1, 5, 1, 0);
        cycle(0, 0, 0, 0);
        do_reset();
        cycle(1, 1, 1, 0);
        cycle(0, 0, 0, 1);

        // Randomised traffic
        for (int i = 0; i < 800; i++) begin
            cycle(($urandom_range(3) != 0), int'($urandom), ($urandom_range(3) == 0),
                  $urandom_range(1) == 1);
        end

        // Drain
        for (int i = 0; i < 4; i++) cycle(0, 0, 0, 1);
        @(negedge clk);
        #2;
        check("drain_queue_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
